hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the decode-stage hazard detector.
- Holds a DEPTH-entry shift register of in-flight destination tags: entry 0 = EXE, entry k = k stages later, last entry = the stage just before writeback.
- Compares decode-stage sources against these tags and raises `hazard` (stall ID/IF, bubble into EXE).
- Supports forwarding / no-forwarding modes, multi-cycle load-use latency, pipeline freeze and flush, and a saturating stall-cycle counter for performance monitoring.

Parameters:
- REG_ADDR_W, 4, register-file address width.
- DEPTH, 2, in-flight stages tracked between ID and WB (2 = EXE, MEM); legal range ≥1.
- LOAD_LAT, 1, number of youngest entries (0..LOAD_LAT-1) whose load result is not yet forwardable; 1 ≤ LOAD_LAT ≤ DEPTH.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- fwd_en  in  1  1 = forwarding unit active.
- freeze  in  1  whole pipeline held (e.g. memory wait).
- flush  in  1  kill the instruction currently in ID (taken branch).
- id_valid  in  1  ID holds a real instruction.
- id_src1  in  REG_ADDR_W  first source (Rn).
- id_src2  in  REG_ADDR_W  second source (Rm/Rd).
- id_two_src  in  1  id_src2 is used.
- id_wb_en  in  1  ID instruction writes a register.
- id_dest  in  REG_ADDR_W  ID destination.
- id_mem_read  in  1  ID instruction is a load.
- cnt_clr  in  1  clear stall counter.
- hazard  out  1  stall request (combinational).
- stall_cnt  out  CNT_W  cycles with hazard=1 and freeze=0, saturating.

Behaviour:
- Entry fields: valid, wb_en, mem_read, dest.
  - An entry matches source s when valid & wb_en & dest == s.
  - The src2 comparison is gated by id_two_src.
- hazard is combinational from the registered entries and the current ID inputs. It is forced to 0 when id_valid=0 or flush=1.
  - fwd_en=0: hazard=1 if any entry 0..DEPTH-1 matches src1 or src2.
  - fwd_en=1: hazard=1 only if a matching entry has index < LOAD_LAT and mem_read=1 (load-use).
- Advance on each clk edge, in priority order:
  - rst=1: all entries cleared (valid=0, fields 0); stall_cnt=0.
  - freeze=1: all entries hold; stall_cnt holds (cnt_clr is still honoured).
  - Otherwise, entry k ← entry k-1 for k ≥ 1, and the oldest entry is retired. Entry 0 ← ID fields with valid=1 if id_valid & ~hazard & ~flush; otherwise entry 0 ← bubble (valid=0).
- flush is sampled only when freeze=0; upstream holds flush during a freeze.
- stall_cnt:
  - cnt_clr=1 → 0; cnt_clr has priority over increment.
  - Otherwise it increments when hazard=1 & freeze=0 and saturates at all-ones.
- Reset values: hazard=0 (all entries invalid), stall_cnt=0.
- Latency:
  - hazard reacts in the same cycle as the ID inputs change.
  - A stalled instruction issues the cycle after the blocking producer leaves the non-forwardable window (fwd_en=1) or after it retires from entry DEPTH-1 (fwd_en=0).
- Register 15 (PC) is not special-cased; decode clears id_wb_en for non-writing ops.
- A mode change on fwd_en takes effect combinationally; no state is affected.

Optional Feature:
- Macro HAZARD_FWD_SEL_EN adds outputs fwd_sel1 and fwd_sel2, width $clog2(DEPTH+1).
  - Value 0 = use register file.
  - Value k = forward from entry k-1, taking the youngest (lowest-index) matching entry.
  - Values are valid when fwd_en=1 and hazard=0.
- Without the macro these ports do not exist and no selection logic is built.

Decomposition:
- Shared package (Constants.v additions): REGISTER_FILE_ADDRESS_LEN default, entry field offsets/width for the packed entry, ZERO/ONE constants.
- One sub-module, hazard_tag_match: compares one source against all entries and returns a per-entry match vector. It is instantiated twice (src1, src2), with the reduction/priority logic kept in the parent.

Test Plan (all with DEPTH=2, LOAD_LAT=1):
- Reset: hold rst=1 with random inputs for 3 cycles → hazard=0, stall_cnt=0, all entries invalid after release.
- No-forwarding RAW:
  - Stimulus: fwd_en=0; issue ADD r3; next cycle ID src1=r3.
  - Response: hazard=1 for 2 cycles (entry0, then entry1), 0 on the third; stall_cnt=2.
- Forwarding load-use:
  - Stimulus: fwd_en=1; issue LDR r5; next ID src2=r5 with two_src=1.
  - Response: hazard=1 for exactly 1 cycle.
  - Same sequence with two_src=0 → hazard=0.
- Freeze:
  - Stimulus: during a stall with freeze=1 for 4 cycles.
  - Response: entries hold, hazard stays 1, stall_cnt unchanged; the stall resumes counting after freeze drops.
- Flush:
  - Stimulus: id_valid=1 with flush=1 and id_wb_en=1, dest=r7; next ID src1=r7, fwd_en=0.
  - Response: hazard=0 (bubble inserted, no tag for r7).
- Saturation/clear:
  - Stimulus: CNT_W=2, continuous hazard for 5 cycles → stall_cnt=3.
  - Then assert cnt_clr together with hazard → stall_cnt=0 on the next edge.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_pkg
// Shared constants for the decode-stage hazard scoreboard: default register
// file address width, bit positions of the fields inside a packed in-flight
// entry, and single-bit ZERO/ONE constants.
// Packed entry layout (LSB first): dest[REG_ADDR_W-1:0], mem_read, wb_en, valid.
// Optional feature macro used by the block: HAZARD_FWD_SEL_EN.
// ---------------------------------------------------------------------------
package hazard_scoreboard_pkg;

    localparam int   REGISTER_FILE_ADDRESS_LEN = 4;
    localparam logic ZERO                      = 1'b0;
    localparam logic ONE                       = 1'b1;

    // Total width of one packed in-flight entry.
    function automatic int entry_width(input int aw);
        return aw + 3;
    endfunction

    // Bit position of the mem_read flag (sits directly above dest).
    function automatic int entry_mr_bit(input int aw);
        return aw;
    endfunction

    // Bit position of the wb_en flag.
    function automatic int entry_wb_bit(input int aw);
        return aw + 1;
    endfunction

    // Bit position of the valid flag (MSB of the entry).
    function automatic int entry_valid_bit(input int aw);
        return aw + 2;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_if
// Groups the decode-side control/operand signals and the scoreboard results.
//   slave  : scoreboard side (receives ID fields and pipeline controls,
//            drives hazard, stall_cnt and, with HAZARD_FWD_SEL_EN defined,
//            fwd_sel1/fwd_sel2).
//   master : decode/controller side.
// Macro: HAZARD_FWD_SEL_EN adds the forwarding-select outputs.
// ---------------------------------------------------------------------------
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = REGISTER_FILE_ADDRESS_LEN,
    parameter int CNT_W      = 16
`ifdef HAZARD_FWD_SEL_EN
    , parameter int DEPTH    = 2
`endif
) ();

    logic                  fwd_en;
    logic                  freeze;
    logic                  flush;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_src1;
    logic [REG_ADDR_W-1:0] id_src2;
    logic                  id_two_src;
    logic                  id_wb_en;
    logic [REG_ADDR_W-1:0] id_dest;
    logic                  id_mem_read;
    logic                  cnt_clr;
    logic                  hazard;
    logic [CNT_W-1:0]      stall_cnt;
`ifdef HAZARD_FWD_SEL_EN
    logic [$clog2(DEPTH+1)-1:0] fwd_sel1;
    logic [$clog2(DEPTH+1)-1:0] fwd_sel2;
`endif

    modport slave (
        input  fwd_en, freeze, flush, id_valid, id_src1, id_src2, id_two_src,
        input  id_wb_en, id_dest, id_mem_read, cnt_clr,
`ifdef HAZARD_FWD_SEL_EN
        output fwd_sel1, fwd_sel2,
`endif
        output hazard, stall_cnt
    );

    modport master (
        output fwd_en, freeze, flush, id_valid, id_src1, id_src2, id_two_src,
        output id_wb_en, id_dest, id_mem_read, cnt_clr,
`ifdef HAZARD_FWD_SEL_EN
        input  fwd_sel1, fwd_sel2,
`endif
        input  hazard, stall_cnt
    );

endinterface

// File: rtl/hazard_tag_match.sv
// ---------------------------------------------------------------------------
// hazard_tag_match
// Compares one decode source register against every in-flight tag and
// returns a per-entry match vector.
//   en    : source is actually read by the ID instruction
//   src   : source register address
//   live  : per-entry valid & wb_en
//   dest  : per-entry destination tag
//   match : per-entry hit (entry 0 = EXE)
// ---------------------------------------------------------------------------
module hazard_tag_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = REGISTER_FILE_ADDRESS_LEN,
    parameter int DEPTH      = 2
) (
    input  logic                             en,
    input  logic [REG_ADDR_W-1:0]            src,
    input  logic [DEPTH-1:0]                 live,
    input  logic [DEPTH-1:0][REG_ADDR_W-1:0] dest,
    output logic [DEPTH-1:0]                 match
);

    // Per-entry tag comparison.
    always_comb begin
        match = {DEPTH{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            match[k] = en & live[k] & (dest[k] == src);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Decode-stage hazard detector tracking DEPTH in-flight destination tags
// (entry 0 = EXE, entry DEPTH-1 = stage just before writeback).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : hazard_scoreboard_if.slave (ID fields, fwd_en, freeze, flush,
//              cnt_clr in; combinational hazard and saturating stall_cnt out)
// Parameters: REG_ADDR_W, DEPTH (>=1), LOAD_LAT (1..DEPTH), CNT_W.
// Macro: HAZARD_FWD_SEL_EN adds fwd_sel1/fwd_sel2 (0 = register file,
// k = forward from entry k-1, youngest match wins).
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = REGISTER_FILE_ADDRESS_LEN,
    parameter int DEPTH      = 2,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  bus
);

    localparam int EW        = entry_width(REG_ADDR_W);
    localparam int MR_BIT    = entry_mr_bit(REG_ADDR_W);
    localparam int WB_BIT    = entry_wb_bit(REG_ADDR_W);
    localparam int VALID_BIT = entry_valid_bit(REG_ADDR_W);

    logic [DEPTH-1:0][EW-1:0]         entries_r;
    logic [DEPTH-1:0]                 live_s;
    logic [DEPTH-1:0]                 mr_s;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] dest_s;
    logic [DEPTH-1:0]                 match1_s;
    logic [DEPTH-1:0]                 match2_s;
    logic [DEPTH-1:0]                 any_s;
    logic                             hazard_raw_s;
    logic                             hazard_s;
    logic                             issue_s;
    logic [EW-1:0]                    id_entry_s;
    logic [CNT_W-1:0]                 stall_cnt_r;

    // Unpack the registered entries into per-field vectors.
    always_comb begin
        live_s = {DEPTH{1'b0}};
        mr_s   = {DEPTH{1'b0}};
        dest_s = {(DEPTH*REG_ADDR_W){1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            live_s[k] = entries_r[k][VALID_BIT] & entries_r[k][WB_BIT];
            mr_s[k]   = entries_r[k][MR_BIT];
            dest_s[k] = entries_r[k][REG_ADDR_W-1:0];
        end
    end

    hazard_tag_match #(.REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH)) u_match_src1 (
        .en    (ONE),
        .src   (bus.id_src1),
        .live  (live_s),
        .dest  (dest_s),
        .match (match1_s)
    );

    hazard_tag_match #(.REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH)) u_match_src2 (
        .en    (bus.id_two_src),
        .src   (bus.id_src2),
        .live  (live_s),
        .dest  (dest_s),
        .match (match2_s)
    );

    // Hazard reduction: with forwarding only a load still inside the
    // non-forwardable window (entries 0..LOAD_LAT-1) blocks the ID stage.
    always_comb begin
        any_s        = match1_s | match2_s;
        hazard_raw_s = ZERO;
        if (bus.fwd_en) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (k < LOAD_LAT) begin
                    hazard_raw_s = hazard_raw_s | (any_s[k] & mr_s[k]);
                end else begin
                    hazard_raw_s = hazard_raw_s;
                end
            end
        end else begin
            hazard_raw_s = |any_s;
        end
        hazard_s   = bus.id_valid & ~bus.flush & hazard_raw_s;
        issue_s    = bus.id_valid & ~bus.flush & ~hazard_s;
        id_entry_s = {ONE, bus.id_wb_en, bus.id_mem_read, bus.id_dest};
    end

    // In-flight tag shift register; a stall or flush pushes a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            entries_r <= {(DEPTH*EW){1'b0}};
        end else if (bus.freeze) begin
            entries_r <= entries_r;
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                entries_r[k] <= entries_r[k-1];
            end
            entries_r[0] <= issue_s ? id_entry_s : {EW{1'b0}};
        end
    end

    // Saturating stall-cycle counter; clear wins over increment and freeze.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (bus.cnt_clr) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (hazard_s & ~bus.freeze & ~(&stall_cnt_r)) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.hazard    = hazard_s;
    assign bus.stall_cnt = stall_cnt_r;

`ifdef HAZARD_FWD_SEL_EN
    localparam int FSEL_W = $clog2(DEPTH+1);

    logic [FSEL_W-1:0] sel1_s;
    logic [FSEL_W-1:0] sel2_s;

    // Forward select: scan oldest to youngest so the youngest match wins.
    always_comb begin
        sel1_s = {FSEL_W{1'b0}};
        sel2_s = {FSEL_W{1'b0}};
        for (int k = DEPTH - 1; k >= 0; k--) begin
            sel1_s = match1_s[k] ? FSEL_W'(k + 1) : sel1_s;
            sel2_s = match2_s[k] ? FSEL_W'(k + 1) : sel2_s;
        end
    end

    assign bus.fwd_sel1 = sel1_s;
    assign bus.fwd_sel2 = sel2_s;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
// Directed scenarios followed by randomized traffic, checked against a
// behavioural model of the in-flight pipeline. A second DUT with CNT_W=2
// shares all inputs to exercise counter saturation.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int AW       = 4;
    localparam int DEPTH    = 2;
    localparam int LOAD_LAT = 1;
    localparam int CNT_W    = 16;
    localparam int CNT_W2   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_ADDR_W(AW), .CNT_W(CNT_W)
`ifdef HAZARD_FWD_SEL_EN
        , .DEPTH(DEPTH)
`endif
    ) hif ();

    hazard_scoreboard_if #(.REG_ADDR_W(AW), .CNT_W(CNT_W2)
`ifdef HAZARD_FWD_SEL_EN
        , .DEPTH(DEPTH)
`endif
    ) hif2 ();

    assign hif2.fwd_en      = hif.fwd_en;
    assign hif2.freeze      = hif.freeze;
    assign hif2.flush       = hif.flush;
    assign hif2.id_valid    = hif.id_valid;
    assign hif2.id_src1     = hif.id_src1;
    assign hif2.id_src2     = hif.id_src2;
    assign hif2.id_two_src  = hif.id_two_src;
    assign hif2.id_wb_en    = hif.id_wb_en;
    assign hif2.id_dest     = hif.id_dest;
    assign hif2.id_mem_read = hif.id_mem_read;
    assign hif2.cnt_clr     = hif.cnt_clr;

    hazard_scoreboard #(.REG_ADDR_W(AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif.slave)
    );

    hazard_scoreboard #(.REG_ADDR_W(AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W2)) dut_w2 (
        .clk (clk),
        .rst (rst),
        .bus (hif2.slave)
    );

    // Behavioural model: one record per in-flight stage, index 0 = EXE.
    typedef struct {
        bit v;
        bit wb;
        bit mr;
        int dest;
    } ent_t;

    ent_t model_q [DEPTH];
    int   model_cnt  = 0;
    int   model_cnt2 = 0;
    int   errors     = 0;
    int   checks     = 0;
    logic obs_hz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit model_hazard();
        if (!hif.id_valid || hif.flush) return 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (model_q[k].v && model_q[k].wb &&
                (model_q[k].dest == int'(hif.id_src1) ||
                 (hif.id_two_src && model_q[k].dest == int'(hif.id_src2)))) begin
                if (!hif.fwd_en) return 1'b1;
                if (k < LOAD_LAT && model_q[k].mr) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic int model_sel(input int src, input bit used);
        for (int k = 0; k < DEPTH; k++) begin
            if (used && model_q[k].v && model_q[k].wb && model_q[k].dest == src) return k + 1;
        end
        return 0;
    endfunction

    // One clock cycle: check hazard mid-cycle, advance model, check counters.
    task automatic step(input bit chk_hz);
        bit exp_hz;
        #4;
        exp_hz = model_hazard();
        obs_hz = hif.hazard;
        if (chk_hz) begin
            check("hazard", 32'(hif.hazard), 32'(exp_hz));
            check("hazard_w2", 32'(hif2.hazard), 32'(exp_hz));
`ifdef HAZARD_FWD_SEL_EN
            if (hif.fwd_en && !exp_hz) begin
                check("fwd_sel1", 32'(hif.fwd_sel1), 32'(model_sel(int'(hif.id_src1), 1'b1)));
                check("fwd_sel2", 32'(hif.fwd_sel2), 32'(model_sel(int'(hif.id_src2), hif.id_two_src)));
            end
`endif
        end
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) model_q[k] = '{v: 1'b0, wb: 1'b0, mr: 1'b0, dest: 0};
            model_cnt  = 0;
            model_cnt2 = 0;
        end else begin
            if (hif.cnt_clr) begin
                model_cnt  = 0;
                model_cnt2 = 0;
            end else if (exp_hz && !hif.freeze) begin
                if (model_cnt < (1 << CNT_W) - 1) model_cnt++;
                if (model_cnt2 < (1 << CNT_W2) - 1) model_cnt2++;
            end
            if (!hif.freeze) begin
                for (int k = DEPTH - 1; k >= 1; k--) model_q[k] = model_q[k-1];
                if (hif.id_valid && !exp_hz && !hif.flush)
                    model_q[0] = '{v: 1'b1, wb: hif.id_wb_en, mr: hif.id_mem_read, dest: int'(hif.id_dest)};
                else
                    model_q[0] = '{v: 1'b0, wb: 1'b0, mr: 1'b0, dest: 0};
            end
        end
        #1;
        check("stall_cnt", 32'(hif.stall_cnt), 32'(model_cnt));
        check("stall_cnt_w2", 32'(hif2.stall_cnt), 32'(model_cnt2));
    endtask

    task automatic set_id(input bit v, input int s1, input int s2, input bit two,
                          input bit wb, input int d, input bit mr);
        hif.id_valid    = v;
        hif.id_src1     = AW'(s1);
        hif.id_src2     = AW'(s2);
        hif.id_two_src  = two;
        hif.id_wb_en    = wb;
        hif.id_dest     = AW'(d);
        hif.id_mem_read = mr;
    endtask

    task automatic idle();
        set_id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        hif.freeze  = 1'b0;
        hif.flush   = 1'b0;
        hif.cnt_clr = 1'b0;
    endtask

    task automatic rand_inputs();
        hif.fwd_en      = 1'($urandom_range(0, 1));
        hif.freeze      = 1'($urandom_range(0, 7) == 0);
        hif.flush       = 1'($urandom_range(0, 7) == 0);
        hif.cnt_clr     = 1'($urandom_range(0, 31) == 0);
        hif.id_valid    = 1'($urandom_range(0, 3) != 0);
        hif.id_src1     = AW'($urandom_range(0, 3));
        hif.id_src2     = AW'($urandom_range(0, 3));
        hif.id_two_src  = 1'($urandom_range(0, 1));
        hif.id_wb_en    = 1'($urandom_range(0, 3) != 0);
        hif.id_dest     = AW'($urandom_range(0, 3));
        hif.id_mem_read = 1'($urandom_range(0, 1));
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) model_q[k] = '{v: 1'b0, wb: 1'b0, mr: 1'b0, dest: 0};
        rand_inputs();

        // Reset held for 3 cycles with random inputs.
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            rst = 1'b1;
            step(1'b0);
        end
        rst = 1'b0;
        idle();
        hif.fwd_en = 1'b0;
        set_id(1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b1, 1'b0, 0, 1'b0);
        step(1'b1);
        check("rst_hz", 32'(obs_hz), 32'd0);

        // No-forwarding RAW.
        idle(); hif.cnt_clr = 1'b1; step(1'b1);
        hif.cnt_clr = 1'b0; hif.fwd_en = 1'b0;
        set_id(1'b1, 0, 0, 1'b0, 1'b1, 3, 1'b0); step(1'b1);
        set_id(1'b1, 3, 0, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1); check("raw_hz1", 32'(obs_hz), 32'd1);
        step(1'b1); check("raw_hz2", 32'(obs_hz), 32'd1);
        step(1'b1); check("raw_hz3", 32'(obs_hz), 32'd0);
        check("raw_cnt", 32'(hif.stall_cnt), 32'd2);

        // Forwarding load-use, src2 used then unused.
        idle(); step(1'b1); step(1'b1);
        hif.fwd_en = 1'b1;
        set_id(1'b1, 0, 0, 1'b0, 1'b1, 5, 1'b1); step(1'b1);
        set_id(1'b1, 0, 5, 1'b1, 1'b0, 0, 1'b0);
        step(1'b1); check("lu_hz1", 32'(obs_hz), 32'd1);
        step(1'b1); check("lu_hz2", 32'(obs_hz), 32'd0);
        idle(); hif.fwd_en = 1'b1; step(1'b1); step(1'b1);
        set_id(1'b1, 0, 0, 1'b0, 1'b1, 5, 1'b1); step(1'b1);
        set_id(1'b1, 0, 5, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1); check("lu_two0", 32'(obs_hz), 32'd0);

        // Freeze during a stall.
        idle(); step(1'b1); step(1'b1);
        hif.cnt_clr = 1'b1; step(1'b1); hif.cnt_clr = 1'b0;
        hif.fwd_en = 1'b0;
        set_id(1'b1, 0, 0, 1'b0, 1'b1, 4, 1'b0); step(1'b1);
        set_id(1'b1, 4, 0, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1); check("fz_cnt0", 32'(hif.stall_cnt), 32'd1);
        hif.freeze = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            check("fz_hz", 32'(obs_hz), 32'd1);
            check("fz_cnt", 32'(hif.stall_cnt), 32'd1);
        end
        hif.freeze = 1'b0;
        step(1'b1); check("fz_resume_hz", 32'(obs_hz), 32'd1);
        check("fz_resume_cnt", 32'(hif.stall_cnt), 32'd2);
        step(1'b1); check("fz_issue_hz", 32'(obs_hz), 32'd0);

        // Flush inserts a bubble instead of the r7 tag.
        idle(); step(1'b1); step(1'b1);
        hif.fwd_en = 1'b0;
        set_id(1'b1, 0, 0, 1'b0, 1'b1, 7, 1'b0); hif.flush = 1'b1;
        step(1'b1); check("fl_hz0", 32'(obs_hz), 32'd0);
        hif.flush = 1'b0;
        set_id(1'b1, 7, 0, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1); check("fl_hz1", 32'(obs_hz), 32'd0);

        // Saturation of the 2-bit counter, then clear during a hazard.
        idle(); step(1'b1); step(1'b1);
        hif.cnt_clr = 1'b1; step(1'b1); hif.cnt_clr = 1'b0;
        hif.fwd_en = 1'b0;
        set_id(1'b1, 9, 0, 1'b0, 1'b1, 9, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1);
        check("sat_cnt_w2", 32'(hif2.stall_cnt), 32'd3);
        check("sat_cnt_w16", 32'(hif.stall_cnt), 32'd5);
        hif.cnt_clr = 1'b1;
        step(1'b1);
        check("clr_hz", 32'(obs_hz), 32'd1);
        check("clr_cnt_w2", 32'(hif2.stall_cnt), 32'd0);
        hif.cnt_clr = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            rst = 1'($urandom_range(0, 63) == 0);
            step(1'b1);
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
